// File: rtl/ps2_host_tx_ctrl.sv
// ============================================================================
// Module   : ps2_host_tx_ctrl
// Purpose  : Host-side PS/2 line owner. Sends host-to-device command frames
//            and arbitrates the open-drain clock/data lines with the receiver.
// Options  : PS2_TX_RETRY_EN - retry a failed byte from inhibit up to 2 times
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       rx_busy_i,
    output logic       rx_inhibit_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic [1:0] err_code_o
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NOACK   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RX   = 3'd1,
        S_INHIBIT   = 3'd2,
        S_RTS       = 3'd3,
        S_SEND      = 3'd4,
        S_ACK       = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_prev_q;
    logic [7:0]       byte_q, byte_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             data_bit_q, data_bit_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    logic       clk_s, data_s, fall;
    logic       active, fail;
    logic [1:0] fail_code;
    logic [9:0] frame;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;
    // Frame bits after the start bit: data LSB first, odd parity, stop.
    assign frame  = {1'b1, ~^byte_q, byte_q};
    assign active = state_q inside {S_RTS, S_SEND, S_ACK, S_WAIT_IDLE};

    assign tx_done_o  = done_q;
    assign tx_err_o   = err_q;
    assign err_code_o = err_code_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            byte_q      <= 8'h00;
            bit_idx_q   <= 4'd0;
            data_bit_q  <= 1'b1;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_s;
            byte_q      <= byte_d;
            bit_idx_q   <= bit_idx_d;
            data_bit_q  <= data_bit_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        bit_idx_d     = bit_idx_q;
        data_bit_d    = data_bit_q;
        inh_cnt_d     = '0;
        to_cnt_d      = '0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
`ifdef PS2_TX_RETRY_EN
        retry_d       = retry_q;
`endif
        ps2_clk_oe_o  = 1'b0;
        ps2_data_oe_o = 1'b0;
        tx_ready_o    = 1'b0;
        rx_inhibit_o  = 1'b0;
        fail          = 1'b0;
        fail_code     = ERR_NONE;

        if (active) begin
            to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_ready_o = 1'b1;
                if (tx_valid_i) begin
                    byte_d     = tx_data_i;
                    err_code_d = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 2'd0;
`endif
                    state_d    = rx_busy_i ? S_WAIT_RX : S_INHIBIT;
                end
            end
            S_WAIT_RX: begin
                if (!rx_busy_i) begin
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe_o = 1'b1;
                rx_inhibit_o = 1'b1;
                inh_cnt_d    = inh_cnt_q + 1'b1;
                // Last inhibit cycle pulls data low before clock is released.
                if (inh_cnt_q == INH_LAST) begin
                    ps2_data_oe_o = 1'b1;
                    state_d       = S_RTS;
                end
            end
            S_RTS: begin
                ps2_data_oe_o = 1'b1;
                rx_inhibit_o  = 1'b1;
                bit_idx_d     = 4'd0;
                if (fall) begin
                    data_bit_d = frame[0];
                    bit_idx_d  = 4'd1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                ps2_data_oe_o = ~data_bit_q;
                rx_inhibit_o  = 1'b1;
                if (fall) begin
                    data_bit_d = frame[bit_idx_q];
                    bit_idx_d  = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                rx_inhibit_o = 1'b1;
                if (fall) begin
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NOACK;
                    end
                end
            end
            S_WAIT_IDLE: begin
                rx_inhibit_o = 1'b1;
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (active && (to_cnt_q == TO_LIMIT)) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end

        if (fail) begin
            done_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                state_d = S_INHIBIT;
            end else begin
                err_d      = 1'b1;
                err_code_d = fail_code;
                state_d    = S_IDLE;
            end
`else
            err_d      = 1'b1;
            err_code_d = fail_code;
            state_d    = S_IDLE;
`endif
        end
    end

endmodule

`default_nettype wire
